// File: rtl/sweep_pkg.sv
// Shared types for the up/down sweep sequencer: controller state encoding
// and counter direction constants.
package sweep_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        UP      = 3'd1,
        HOLD_HI = 3'd2,
        DOWN    = 3'd3,
        HOLD_LO = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/sudc_en.sv
// Synchronous up/down counter with enable and parallel load.
// Load has priority over counting; direction 1 counts up.
module sudc_en #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic             up,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q
);

    localparam logic [WIDTH-1:0] W_ONE = 1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (en) begin
            q <= up ? q + W_ONE : q - W_ONE;
        end
    end

endmodule

// File: rtl/updown_sweep_ctrl.sv
// Sequencer driving an up/down counter through repeated triangular sweeps
// lo -> hi -> lo with optional dwell at each extreme.
module updown_sweep_ctrl
    import sweep_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int HOLD_W = 4,
    parameter int REP_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [WIDTH-1:0]  lo,
    input  logic [WIDTH-1:0]  hi,
    input  logic [HOLD_W-1:0] hold,
    input  logic [REP_W-1:0]  reps,
    output logic [WIDTH-1:0]  q,
    output logic              up_down,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [WIDTH-1:0]  W_ONE = 1;
    localparam logic [HOLD_W-1:0] H_ONE = 1;
    localparam logic [REP_W-1:0]  R_ONE = 1;

    state_t             state;
    logic [WIDTH-1:0]   lo_l, hi_l;
    logic [HOLD_W-1:0]  hold_l, hold_cnt;
    logic [REP_W-1:0]   rep_cnt;
    logic [WIDTH-1:0]   q_inc, q_dec;
    logic               start_ok, busy_st, cnt_en, cnt_load, last_rep;

    assign q_inc    = q + W_ONE;
    assign q_dec    = q - W_ONE;
    assign start_ok = (lo < hi) && (reps != '0);
    assign busy_st  = (state == UP) || (state == HOLD_HI) ||
                      (state == DOWN) || (state == HOLD_LO);
    assign last_rep = (rep_cnt == R_ONE);

    // The counter loads lo from the live inputs on the same edge the config is latched.
    assign cnt_load = (state == IDLE) && start && start_ok;
    assign cnt_en   = ((state == UP) || (state == DOWN)) && !abort;

    sudc_en #(.WIDTH(WIDTH)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .en       (cnt_en),
        .load     (cnt_load),
        .up       (up_down),
        .load_val (lo),
        .q        (q)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            up_down  <= DIR_UP;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            lo_l     <= '0;
            hi_l     <= '0;
            hold_l   <= '0;
            hold_cnt <= '0;
            rep_cnt  <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (busy_st && abort) begin
                state   <= IDLE;
                busy    <= 1'b0;
                up_down <= DIR_UP;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && start_ok) begin
                            lo_l    <= lo;
                            hi_l    <= hi;
                            hold_l  <= hold;
                            rep_cnt <= reps;
                            up_down <= DIR_UP;
                            busy    <= 1'b1;
                            state   <= UP;
                        end else if (start) begin
                            err <= 1'b1;
                        end
                    end
                    UP: begin
                        if (q_inc == hi_l) begin
                            if (hold_l != '0) begin
                                hold_cnt <= hold_l - H_ONE;
                                state    <= HOLD_HI;
                            end else begin
                                up_down <= DIR_DN;
                                state   <= DOWN;
                            end
                        end
                    end
                    HOLD_HI: begin
                        if (hold_cnt == '0) begin
                            up_down <= DIR_DN;
                            state   <= DOWN;
                        end else begin
                            hold_cnt <= hold_cnt - H_ONE;
                        end
                    end
                    DOWN: begin
                        if (q_dec == lo_l) begin
                            rep_cnt <= rep_cnt - R_ONE;
                            if (hold_l != '0) begin
                                hold_cnt <= hold_l - H_ONE;
                                state    <= HOLD_LO;
                            end else if (last_rep) begin
                                done  <= 1'b1;
                                state <= DONE;
                            end else begin
                                up_down <= DIR_UP;
                                state   <= UP;
                            end
                        end
                    end
                    HOLD_LO: begin
                        // rep_cnt was already decremented on the way into this dwell.
                        if (hold_cnt == '0) begin
                            if (rep_cnt == '0) begin
                                done  <= 1'b1;
                                state <= DONE;
                            end else begin
                                up_down <= DIR_UP;
                                state   <= UP;
                            end
                        end else begin
                            hold_cnt <= hold_cnt - H_ONE;
                        end
                    end
                    DONE: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Self-checking bench for updown_sweep_ctrl: start-response vector table,
// directed multi-cycle sequences and randomized sweeps against a trace model.
module tb_updown_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] lo_i = '0, hi_i = '0, hold_i = '0, reps_i = '0;
    logic [3:0] q;
    logic       up_down, busy, done, err;

    int n_checks = 0;
    int n_fail   = 0;

    updown_sweep_ctrl #(.WIDTH(4), .HOLD_W(4), .REP_W(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .abort   (abort),
        .lo      (lo_i),
        .hi      (hi_i),
        .hold    (hold_i),
        .reps    (reps_i),
        .q       (q),
        .up_down (up_down),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int q;
        int ud;
        int dn;
    } cyc_t;

    cyc_t trace[$];

    typedef struct {
        bit start;
        int lo;
        int hi;
        int hold;
        int reps;
        int exp_err;
        int exp_busy;
        int exp_q;
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // One complete run as a list of per-cycle observations, built from the sweep shape.
    task automatic build_trace(input int l, input int h, input int hd, input int rp);
        trace.delete();
        for (int r = 0; r < rp; r++) begin
            for (int v = l; v < h; v++) trace.push_back('{v, 1, 0});
            for (int d = 0; d < hd; d++) trace.push_back('{h, 1, 0});
            for (int v = h; v > l; v--) trace.push_back('{v, 0, 0});
            for (int d = 0; d < hd; d++) trace.push_back('{l, 0, 0});
        end
        trace.push_back('{l, 0, 1});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ab: cycle index at which abort is raised (-1 for none); scr scrambles inputs while busy.
    task automatic run_sweep(input int l, input int h, input int hd, input int rp,
                             input int ab, input bit scr, input string tag);
        int len;
        build_trace(l, h, hd, rp);
        len = trace.size();
        lo_i = 4'(l); hi_i = 4'(h); hold_i = 4'(hd); reps_i = 4'(rp);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < len; k++) begin
            chk($sformatf("%s q[%0d]", tag, k), int'(q), trace[k].q);
            chk($sformatf("%s up_down[%0d]", tag, k), int'(up_down), trace[k].ud);
            chk($sformatf("%s busy[%0d]", tag, k), int'(busy), 1);
            chk($sformatf("%s done[%0d]", tag, k), int'(done), trace[k].dn);
            chk($sformatf("%s err[%0d]", tag, k), int'(err), 0);
            if (scr) begin
                lo_i   = 4'($urandom);
                hi_i   = 4'($urandom);
                hold_i = 4'($urandom);
                reps_i = 4'($urandom);
                start  = (k < len - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            abort = (k == ab);
            tick();
            abort = 1'b0;
            if (k == ab && k < len - 1) begin
                start = 1'b0;
                chk($sformatf("%s abort q", tag), int'(q), trace[k].q);
                chk($sformatf("%s abort busy", tag), int'(busy), 0);
                chk($sformatf("%s abort done", tag), int'(done), 0);
                chk($sformatf("%s abort up_down", tag), int'(up_down), 1);
                return;
            end
        end
        start = 1'b0;
        chk($sformatf("%s post busy", tag), int'(busy), 0);
        chk($sformatf("%s post done", tag), int'(done), 0);
        chk($sformatf("%s post q", tag), int'(q), l);
        chk($sformatf("%s post err", tag), int'(err), 0);
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{1'b0,  3,  9, 0,  1, 0, 0, 0};
        vecs[1] = '{1'b1,  7,  7, 0,  1, 1, 0, 0};
        vecs[2] = '{1'b1,  7,  7, 0,  0, 1, 0, 0};
        vecs[3] = '{1'b1,  2,  9, 1,  0, 1, 0, 0};
        vecs[4] = '{1'b1,  9,  2, 0,  3, 1, 0, 0};
        vecs[5] = '{1'b1,  4,  5, 0,  1, 0, 1, 4};
        vecs[6] = '{1'b1, 15,  0, 2,  1, 1, 0, 4};
        vecs[7] = '{1'b1,  0, 15, 3, 15, 0, 1, 0};
        vecs[8] = '{1'b0,  6,  8, 0,  2, 0, 0, 0};

        // Reset state, held across clock edges.
        #12;
        chk("reset q", int'(q), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset up_down", int'(up_down), 1);
        chk("reset done", int'(done), 0);
        chk("reset err", int'(err), 0);
        rst = 1'b1;
        tick();

        // Start response table: reject/accept decision on one cycle.
        foreach (vecs[i]) begin
            lo_i = 4'(vecs[i].lo); hi_i = 4'(vecs[i].hi);
            hold_i = 4'(vecs[i].hold); reps_i = 4'(vecs[i].reps);
            start = vecs[i].start;
            tick();
            chk($sformatf("vec%0d err", i), int'(err), vecs[i].exp_err);
            chk($sformatf("vec%0d busy", i), int'(busy), vecs[i].exp_busy);
            chk($sformatf("vec%0d q", i), int'(q), vecs[i].exp_q);
            start = 1'b0;
            abort = 1'(vecs[i].exp_busy);
            tick();
            abort = 1'b0;
            chk($sformatf("vec%0d err clear", i), int'(err), 0);
            chk($sformatf("vec%0d busy after", i), int'(busy), 0);
            chk($sformatf("vec%0d q after", i), int'(q), vecs[i].exp_q);
            chk($sformatf("vec%0d up_down", i), int'(up_down), 1);
        end

        run_sweep(2, 5, 0, 1, -1, 1'b0, "basic");
        run_sweep(0, 3, 2, 2, -1, 1'b0, "dwell");
        // q sequence 1,2,3,4,5,6,5,4: index 7 is DOWN at q=4.
        run_sweep(1, 6, 0, 1, 7, 1'b0, "abort_down");
        run_sweep(3, 8, 1, 1, -1, 1'b0, "after_abort");
        // lo=1,hi=3,hold=0,reps=1: 1,2,3,2,DONE(1); index 3 is the terminal DOWN cycle.
        run_sweep(1, 3, 0, 1, 3, 1'b0, "abort_terminal");
        run_sweep(1, 3, 0, 1, 4, 1'b0, "abort_in_done");
        run_sweep(1, 4, 2, 2, -1, 1'b1, "immune");

        // Asynchronous reset in the middle of a clock period during HOLD_HI.
        lo_i = 4'd2; hi_i = 4'd10; hold_i = 4'd5; reps_i = 4'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        chk("pre-reset q", int'(q), 10);
        chk("pre-reset busy", int'(busy), 1);
        #3 rst = 1'b0;
        #1;
        chk("async q", int'(q), 0);
        chk("async busy", int'(busy), 0);
        chk("async up_down", int'(up_down), 1);
        chk("async done", int'(done), 0);
        #2 rst = 1'b1;
        tick();
        chk("post-reset busy", int'(busy), 0);
        run_sweep(5, 7, 1, 1, -1, 1'b0, "after_reset");

        // Randomized runs against the trace model, with occasional aborts and rejects.
        for (int it = 0; it < 30; it++) begin
            int l, h, hd, rp, len, ab;
            if ($urandom_range(0, 4) == 0) begin
                int q0;
                q0 = int'(q);
                l = $urandom_range(0, 15);
                h = $urandom_range(0, l);
                lo_i = 4'(l); hi_i = 4'(h); reps_i = 4'($urandom_range(1, 3));
                if ($urandom_range(0, 1) == 1) begin
                    hi_i = 4'($urandom_range(0, 15)); lo_i = 4'($urandom_range(0, 15));
                    reps_i = 4'd0;
                end
                start = 1'b1;
                tick();
                start = 1'b0;
                chk($sformatf("rnd%0d reject err", it), int'(err), 1);
                chk($sformatf("rnd%0d reject busy", it), int'(busy), 0);
                chk($sformatf("rnd%0d reject q", it), int'(q), q0);
                tick();
                chk($sformatf("rnd%0d err pulse", it), int'(err), 0);
            end else begin
                l  = $urandom_range(0, 12);
                h  = $urandom_range(l + 1, 15);
                hd = $urandom_range(0, 3);
                rp = $urandom_range(1, 3);
                len = rp * (2 * (h - l) + 2 * hd) + 1;
                ab = ($urandom_range(0, 2) == 0) ? $urandom_range(0, len - 1) : -1;
                run_sweep(l, h, hd, rp, ab, 1'($urandom_range(0, 1)),
                          $sformatf("rnd%0d", it));
            end
            if ($urandom_range(0, 1) == 1) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
